// File: rtl/switch_egress_arbiter_if.sv
// Handshake bundle between the ingress-port request side and one per-output
// egress arbiter.
//   master : requester side (drives enable/req/req_mask, observes grant side)
//   slave  : arbiter side   (observes requests, drives grant/mux controls)
// Signals:
//   enable      arbitration allowed when 1
//   req         per-port ARB_WAIT request for this output
//   req_mask    per-port request mask (1 = ignore that port)
//   grant       one-hot single-cycle grant pulse
//   arb_active  high exactly while grant is non-zero
//   mux_select  index of the current/last winner
//   busy        high during GRANT and COOL
//   grant_count saturating count of grants issued
interface switch_egress_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int SEL_W   = $clog2(N_PORTS),
  parameter int CNT_W   = 16
);
  logic               enable;
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] req_mask;
  logic [N_PORTS-1:0] grant;
  logic               arb_active;
  logic [SEL_W-1:0]   mux_select;
  logic               busy;
  logic [CNT_W-1:0]   grant_count;

  modport master (
    output enable, req, req_mask,
    input  grant, arb_active, mux_select, busy, grant_count
  );

  modport slave (
    input  enable, req, req_mask,
    output grant, arb_active, mux_select, busy, grant_count
  );
endinterface

// File: rtl/switch_egress_arbiter.sv
// Per-output-port round-robin arbiter (one instance per switch output).
// Picks among ingress ports requesting this output, issues a registered
// one-cycle grant pulse plus the egress mux controls, then spends one cool
// cycle covering the winner's FIFO pop before arbitrating again.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    switch_egress_arbiter_if.slave (requests in, grant/mux/status out)
module switch_egress_arbiter #(
  parameter int N_PORTS = 4,
  parameter int SEL_W   = $clog2(N_PORTS),
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  switch_egress_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [N_PORTS-1:0] eff_req;
  logic [SEL_W-1:0]   cand;
  logic [SEL_W-1:0]   winner;
  logic               winner_vld;

  // Round-robin search starting at ptr. The loop runs from the farthest
  // offset down to offset 0 so the nearest requester (in wrap order) is the
  // last one written and therefore wins. N_PORTS is a power of two, so the
  // SEL_W-bit add wraps modulo N_PORTS for free.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    eff_req    = bus.req & ~bus.req_mask;
    cand       = ptr;
    winner     = ptr;
    winner_vld = 1'b0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (eff_req[cand]) begin
        winner     = cand;
        winner_vld = 1'b1;
      end
    end
  end

  // Single registered FSM; every output comes straight from a flop so there
  // is no combinational path from req to grant.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      bus.grant       <= '0;
      bus.arb_active  <= 1'b0;
      bus.mux_select  <= '0;
      bus.busy        <= 1'b0;
      bus.grant_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable && winner_vld) begin
            state          <= GRANT;
            bus.grant      <= {{(N_PORTS-1){1'b0}}, 1'b1} << winner;
            bus.arb_active <= 1'b1;
            bus.mux_select <= winner;
            bus.busy       <= 1'b1;
            if (bus.grant_count != {CNT_W{1'b1}})
              bus.grant_count <= bus.grant_count + 1'b1;
          end
        end
        GRANT: begin
          // Unconditional: a dropped req or mask change does not abort.
          state          <= COOL;
          bus.grant      <= '0;
          bus.arb_active <= 1'b0;
          ptr            <= bus.mux_select + 1'b1;
        end
        COOL: begin
          // Winner pops its FIFO this cycle; its req may still be high but
          // cannot be re-granted until the next IDLE evaluation.
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          bus.grant      <= '0;
          bus.arb_active <= 1'b0;
          bus.busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_egress_arbiter.sv
// Directed self-checking bench for switch_egress_arbiter.
// dut  : N_PORTS=4, CNT_W=16 (main scenarios)
// dut2 : N_PORTS=4, CNT_W=3  (grant counter saturation)
module tb_switch_egress_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  switch_egress_arbiter_if #(.N_PORTS(4), .SEL_W(2), .CNT_W(16)) bus ();
  switch_egress_arbiter_if #(.N_PORTS(4), .SEL_W(2), .CNT_W(3))  bus2 ();

  switch_egress_arbiter #(.N_PORTS(4), .SEL_W(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  switch_egress_arbiter #(.N_PORTS(4), .SEL_W(2), .CNT_W(3)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full arbitration: IDLE evaluation edge -> GRANT cycle -> COOL cycle -> IDLE.
  task automatic grant_seq(input string tag, input logic [3:0] exp_grant,
                           input logic [1:0] exp_sel, input int exp_cnt);
    tick();
    check({tag, " grant"},      32'(bus.grant),       32'(exp_grant));
    check({tag, " arb_active"}, 32'(bus.arb_active),  32'd1);
    check({tag, " mux_select"}, 32'(bus.mux_select),  32'(exp_sel));
    check({tag, " busy"},       32'(bus.busy),        32'd1);
    check({tag, " count"},      32'(bus.grant_count), 32'(exp_cnt));
    tick();
    check({tag, " cool grant"}, 32'(bus.grant),       32'd0);
    check({tag, " cool arb"},   32'(bus.arb_active),  32'd0);
    check({tag, " cool busy"},  32'(bus.busy),        32'd1);
    check({tag, " cool sel"},   32'(bus.mux_select),  32'(exp_sel));
    tick();
    check({tag, " idle grant"}, 32'(bus.grant),       32'd0);
    check({tag, " idle busy"},  32'(bus.busy),        32'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.enable    = 1'b1;
    bus.req       = 4'b0000;
    bus.req_mask  = 4'b0000;
    bus2.enable   = 1'b1;
    bus2.req      = 4'b0001;
    bus2.req_mask = 4'b0000;

    // Reset values
    #2;
    check("rst grant",      32'(bus.grant),       32'd0);
    check("rst arb_active", 32'(bus.arb_active),  32'd0);
    check("rst mux_select", 32'(bus.mux_select),  32'd0);
    check("rst busy",       32'(bus.busy),        32'd0);
    check("rst count",      32'(bus.grant_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single requester on port 2
    bus.req = 4'b0100;
    grant_seq("t1", 4'b0100, 2'd2, 1);
    bus.req = 4'b0000;
    tick();
    check("t1 no regrant", 32'(bus.grant), 32'd0);

    // ptr is now 3: wrap-around picks port 0, then port 1
    bus.req = 4'b0011;
    grant_seq("t3 wrap", 4'b0001, 2'd0, 2);
    grant_seq("t3 next", 4'b0010, 2'd1, 3);
    bus.req = 4'b0000;

    // All four requesting: 0,1,2,3,0 every third cycle
    do_reset();
    bus.req = 4'b1111;
    grant_seq("t2 p0", 4'b0001, 2'd0, 1);
    grant_seq("t2 p1", 4'b0010, 2'd1, 2);
    grant_seq("t2 p2", 4'b0100, 2'd2, 3);
    grant_seq("t2 p3", 4'b1000, 2'd3, 4);
    grant_seq("t2 p0b", 4'b0001, 2'd0, 5);

    // Masked ports 0 and 2: 1 and 3 alternate
    do_reset();
    bus.req      = 4'b1111;
    bus.req_mask = 4'b0101;
    grant_seq("t4 p1", 4'b0010, 2'd1, 1);
    grant_seq("t4 p3", 4'b1000, 2'd3, 2);
    grant_seq("t4 p1b", 4'b0010, 2'd1, 3);
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4 disabled grant", 32'(bus.grant),       32'd0);
      check("t4 disabled busy",  32'(bus.busy),        32'd0);
      check("t4 frozen count",   32'(bus.grant_count), 32'd3);
    end
    // ptr retained at 2 while disabled, so port 3 is next
    bus.enable = 1'b1;
    grant_seq("t4 resume", 4'b1000, 2'd3, 4);
    bus.req_mask = 4'b0000;

    // Async reset in the middle of a GRANT cycle
    do_reset();
    bus.req = 4'b1111;
    tick();
    check("t5 pre grant", 32'(bus.grant), 32'b0001);
    rst_n = 1'b0;
    #1;
    check("t5 async grant", 32'(bus.grant),       32'd0);
    check("t5 async arb",   32'(bus.arb_active),  32'd0);
    check("t5 async busy",  32'(bus.busy),        32'd0);
    check("t5 async sel",   32'(bus.mux_select),  32'd0);
    check("t5 async count", 32'(bus.grant_count), 32'd0);
    bus.req = 4'b1000;
    #1;
    rst_n = 1'b1;
    grant_seq("t5 after", 4'b1000, 2'd3, 1);
    bus.req = 4'b0000;

    // 3-bit counter saturation on dut2 (req=0001 held)
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6 grant", 32'(bus2.grant),       32'b0001);
      check("t6 count", 32'(bus2.grant_count), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
      tick();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
